wb_stage: RTL

Registered, parametrised write-back stage: captures one instruction per cycle from the MEM stage behind a valid/ready handshake, waits on late load data, aligns and sign/zero-extends loaded bytes/halves/words, and selects the register-file write value from ALU result, load data or PC+4. Sits between the MEM stage and the register file; its outputs drive the register-file write port directly.

---
 rtl/wb_stage_if.sv | 36 +++
 rtl/wb_stage.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/wb_stage_if.sv
// MEM -> write-back bundle: instruction fields, late load data and the register-file write port.
// Handshake: an instruction transfers on a rising edge where valid_in & ready_out & !flush;
// the master holds its fields stable while valid_in is high and ready_out is low.
interface wb_stage_if #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
);
    logic            flush;
    logic            valid_in;
    logic            ready_out;
    logic            Ctl_RegWrite_in;
    logic            Ctl_MemRead_in;
    logic [1:0]      Ctl_WbSel_in;
    logic [2:0]      Funct3_in;
    logic [RA_W-1:0] Rd_in;
    logic [XLEN-1:0] ALUresult_in;
    logic [XLEN-1:0] PCplus4_in;
    logic [XLEN-1:0] MemRdata_in;
    logic            MemRvalid_in;
    logic            Ctl_RegWrite_out;
    logic [RA_W-1:0] Rd_out;
    logic [XLEN-1:0] WriteDatatoReg_out;
    logic            retire_out;

    modport master (
        output flush, valid_in, Ctl_RegWrite_in, Ctl_MemRead_in, Ctl_WbSel_in, Funct3_in,
               Rd_in, ALUresult_in, PCplus4_in, MemRdata_in, MemRvalid_in,
        input  ready_out, Ctl_RegWrite_out, Rd_out, WriteDatatoReg_out, retire_out
    );

    modport slave (
        input  flush, valid_in, Ctl_RegWrite_in, Ctl_MemRead_in, Ctl_WbSel_in, Funct3_in,
               Rd_in, ALUresult_in, PCplus4_in, MemRdata_in, MemRvalid_in,
        output ready_out, Ctl_RegWrite_out, Rd_out, WriteDatatoReg_out, retire_out
    );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: accepts one instruction per cycle, waits for late load data, extracts and
// extends load data, drives the register-file write port. Optional counter: WB_RETIRE_CNT_EN.
module wb_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic        clk,
    input  logic        rst,
    wb_stage_if.slave   bus,
`ifdef WB_RETIRE_CNT_EN
    output logic [63:0] retire_cnt_out,
`endif
    output logic [1:0]  state_dbg_out
);
    localparam int OFF_W = $clog2(XLEN / 8);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_WAIT  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            regwrite_q, regwrite_d;
    logic [1:0]      wbsel_q, wbsel_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [RA_W-1:0] rd_q, rd_d;
    logic [XLEN-1:0] alu_q, alu_d;
    logic [XLEN-1:0] pc4_q, pc4_d;
    logic            rw_out_q, rw_out_d;
    logic [RA_W-1:0] rd_out_q, rd_out_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic            retire_q, retire_d;

    logic            ready;
    logic            accept;
    logic            wr_go;
    logic            src_rw;
    logic [1:0]      src_sel;
    logic [2:0]      src_f3;
    logic [RA_W-1:0] src_rd;
    logic [XLEN-1:0] src_alu;
    logic [XLEN-1:0] src_pc4;

    // Misaligned offsets are masked down to the access size rather than trapped.
    function automatic logic [XLEN-1:0] load_extract(input logic [2:0] f3,
                                                     input logic [OFF_W-1:0] off,
                                                     input logic [XLEN-1:0] raw);
        logic [OFF_W+2:0] sh;
        logic [XLEN-1:0]  s;
        logic [XLEN-1:0]  r;
        case (f3[1:0])
            2'b00:   sh = {off, 3'b000};
            2'b01:   sh = {off & ~OFF_W'(1), 3'b000};
            2'b10:   sh = {off & ~OFF_W'(3), 3'b000};
            default: sh = '0;
        endcase
        s = raw >> sh;
        case (f3)
            3'b000:  r = XLEN'($signed(s[7:0]));
            3'b100:  r = XLEN'(s[7:0]);
            3'b001:  r = XLEN'($signed(s[15:0]));
            3'b101:  r = XLEN'(s[15:0]);
            3'b010:  r = XLEN'($signed(s[31:0]));
            3'b110:  r = XLEN'(s[31:0]);
            default: r = s;
        endcase
        return r;
    endfunction

    assign ready  = (state_q != S_WAIT);
    assign accept = bus.valid_in & ready & ~bus.flush;

    // On accept the write is built straight from the inputs; after WAIT from the latched copy.
    assign src_rw  = accept ? bus.Ctl_RegWrite_in : regwrite_q;
    assign src_sel = accept ? bus.Ctl_WbSel_in    : wbsel_q;
    assign src_f3  = accept ? bus.Funct3_in       : funct3_q;
    assign src_rd  = accept ? bus.Rd_in           : rd_q;
    assign src_alu = accept ? bus.ALUresult_in    : alu_q;
    assign src_pc4 = accept ? bus.PCplus4_in      : pc4_q;

    always_comb begin
        state_d    = state_q;
        regwrite_d = regwrite_q;
        wbsel_d    = wbsel_q;
        funct3_d   = funct3_q;
        rd_d       = rd_q;
        alu_d      = alu_q;
        pc4_d      = pc4_q;
        rw_out_d   = 1'b0;
        rd_out_d   = rd_out_q;
        wdata_d    = wdata_q;
        retire_d   = 1'b0;
        wr_go      = 1'b0;

        if (accept) begin
            regwrite_d = bus.Ctl_RegWrite_in;
            wbsel_d    = bus.Ctl_WbSel_in;
            funct3_d   = bus.Funct3_in;
            rd_d       = bus.Rd_in;
            alu_d      = bus.ALUresult_in;
            pc4_d      = bus.PCplus4_in;
        end

        if (bus.flush) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_WAIT: begin
                    if (bus.MemRvalid_in) begin
                        state_d = S_WRITE;
                        wr_go   = 1'b1;
                    end
                end
                default: begin
                    if (accept) begin
                        if (!bus.Ctl_MemRead_in || bus.MemRvalid_in) begin
                            state_d = S_WRITE;
                            wr_go   = 1'b1;
                        end else begin
                            state_d = S_WAIT;
                        end
                    end else begin
                        state_d = S_EMPTY;
                    end
                end
            endcase
        end

        if (wr_go) begin
            rw_out_d = src_rw & (src_rd != '0);
            rd_out_d = src_rd;
            retire_d = 1'b1;
            case (src_sel)
                2'b01:   wdata_d = load_extract(src_f3, src_alu[OFF_W-1:0], bus.MemRdata_in);
                2'b10:   wdata_d = src_pc4;
                default: wdata_d = src_alu;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_EMPTY;
            regwrite_q <= 1'b0;
            wbsel_q    <= '0;
            funct3_q   <= '0;
            rd_q       <= '0;
            alu_q      <= '0;
            pc4_q      <= '0;
            rw_out_q   <= 1'b0;
            rd_out_q   <= '0;
            wdata_q    <= '0;
            retire_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            regwrite_q <= regwrite_d;
            wbsel_q    <= wbsel_d;
            funct3_q   <= funct3_d;
            rd_q       <= rd_d;
            alu_q      <= alu_d;
            pc4_q      <= pc4_d;
            rw_out_q   <= rw_out_d;
            rd_out_q   <= rd_out_d;
            wdata_q    <= wdata_d;
            retire_q   <= retire_d;
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_cnt_q, retire_cnt_d;

    assign retire_cnt_d = retire_cnt_q + 64'(retire_q);

    always_ff @(posedge clk) begin
        if (rst) retire_cnt_q <= '0;
        else     retire_cnt_q <= retire_cnt_d;
    end

    assign retire_cnt_out = retire_cnt_q;
`endif

    assign bus.ready_out          = ready;
    assign bus.Ctl_RegWrite_out   = rw_out_q;
    assign bus.Rd_out             = rd_out_q;
    assign bus.WriteDatatoReg_out = wdata_q;
    assign bus.retire_out         = retire_q;
    assign state_dbg_out          = state_q;
endmodule
